// File: rtl/mac_acc_if.sv
// mac_acc_if: operand / result bundle for one multiply-accumulate element.
//   en, clear   : sample operands this edge / start a new dot product
//   a, b        : signed operands, IN_W bits
//   acc, ovf    : registered signed accumulator and sticky overflow flag
// master drives operands (sequencer side), slave is the MAC itself.
interface mac_acc_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 32
);
  logic                    en;
  logic                    clear;
  logic signed [IN_W-1:0]  a;
  logic signed [IN_W-1:0]  b;
  logic signed [ACC_W-1:0] acc;
  logic                    ovf;

  modport master (output en, clear, a, b, input  acc, ovf);
  modport slave  (input  en, clear, a, b, output acc, ovf);
endinterface

// File: rtl/mac_acc.sv
// mac_acc: signed multiply-accumulate processing element, 2-stage pipeline.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active HIGH despite the name
//   bus   : mac_acc_if slave (en, clear, a, b in; acc, ovf out)
// Stage 1 registers the exact 2*IN_W-bit product; stage 2 adds it into the
// ACC_W-bit accumulator. Operands sampled at edge N show up in acc after N+1.
module mac_acc #(
  parameter int IN_W     = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  mac_acc_if.slave bus
);
  localparam int PW = 2 * IN_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [PW-1:0]    a_x, b_x, mult;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic                    vld_q, vld_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic signed [ACC_W-1:0] prod_ext, sum;
  logic                    ovf_now;

  // Operands widened to full product width before multiplying so that
  // (-2^(IN_W-1))^2 is represented exactly.
  assign a_x  = {{IN_W{bus.a[IN_W-1]}}, bus.a};
  assign b_x  = {{IN_W{bus.b[IN_W-1]}}, bus.b};
  assign mult = a_x * b_x;

  always_comb begin
    prod_d = prod_q;
    vld_d  = bus.en;
    if (bus.en) prod_d = mult;
  end

  // Signed overflow: both addends share a sign and the sum's sign flipped.
  assign prod_ext = ACC_W'(prod_q);
  assign sum      = acc_q + prod_ext;
  assign ovf_now  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (bus.clear) begin
      // Drops whatever product is in stage 2; stage 1 still captures.
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (vld_q) begin
      ovf_d = ovf_q | ovf_now;
      if ((SATURATE != 0) && ovf_now)
        acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
      else
        acc_d = sum;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= vld_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.acc = acc_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_mac_acc.sv
module tb_mac_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, clear = 1'b0;
  logic signed [7:0] a = '0, b = '0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Main 32-bit wrapping unit plus two narrow units so overflow is reachable
  // in a few cycles; all three see the same stimulus.
  mac_acc_if #(.IN_W(8), .ACC_W(32)) ifm ();
  mac_acc_if #(.IN_W(8), .ACC_W(16)) ifw ();
  mac_acc_if #(.IN_W(8), .ACC_W(16)) ifs ();

  assign ifm.en = en; assign ifm.clear = clear; assign ifm.a = a; assign ifm.b = b;
  assign ifw.en = en; assign ifw.clear = clear; assign ifw.a = a; assign ifw.b = b;
  assign ifs.en = en; assign ifs.clear = clear; assign ifs.a = a; assign ifs.b = b;

  mac_acc #(.IN_W(8), .ACC_W(32), .SATURATE(0)) u_main (.clk(clk), .rst_n(rst), .bus(ifm.slave));
  mac_acc #(.IN_W(8), .ACC_W(16), .SATURATE(0)) u_wrap (.clk(clk), .rst_n(rst), .bus(ifw.slave));
  mac_acc #(.IN_W(8), .ACC_W(16), .SATURATE(1)) u_sat  (.clk(clk), .rst_n(rst), .bus(ifs.slave));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    @(posedge clk); @(posedge clk); #1;
    chk("rst_acc", int'(ifm.acc), 0);
    chk("rst_ovf", int'(ifm.ovf), 0);
    @(negedge clk); rst = 1'b0;

    // 1: single product, latency and hold
    en = 1; a = 3; b = 4; tick();
    en = 0;
    chk("t1_latency", int'(ifm.acc), 0);
    tick(); chk("t1_acc", int'(ifm.acc), 12);
    tick(); chk("t1_hold", int'(ifm.acc), 12);

    // 2: clear then new product
    clear = 1; tick(); clear = 0;
    chk("t2_clear", int'(ifm.acc), 0);
    en = 1; a = 5; b = -2; tick(); en = 0;
    tick(); chk("t2_acc", int'(ifm.acc), -10);

    // 3: back-to-back accumulation
    clear = 1; tick(); clear = 0;
    en = 1; a = 1;  b = 2;  tick();
    a = 3;  b = 4;  tick(); chk("t3_s1", int'(ifm.acc), 2);
    a = -5; b = 6;  tick(); chk("t3_s2", int'(ifm.acc), 14);
    a = 7;  b = -8; tick(); chk("t3_s3", int'(ifm.acc), -16);
    en = 0;         tick(); chk("t3_s4", int'(ifm.acc), -72);
    tick();                 chk("t3_hold", int'(ifm.acc), -72);

    // 4: extreme operands
    clear = 1; tick(); clear = 0;
    en = 1; a = -128; b = -128; tick();
    a = -128; b = 127; tick(); chk("t4_minmin", int'(ifm.acc), 16384);
    tick();                    chk("t4_dec1", int'(ifm.acc), 128);
    en = 0; tick();            chk("t4_dec2", int'(ifm.acc), -16128);

    // 5: clear with en while a product is in flight
    clear = 1; tick(); clear = 0;
    en = 1; a = 3; b = 3; tick();
    clear = 1; a = 2; b = 3; tick();
    clear = 0; en = 0;
    chk("t5_drop", int'(ifm.acc), 0);
    tick(); chk("t5_new", int'(ifm.acc), 6);

    // 6: positive overflow on 16-bit units (16384 + 16384)
    clear = 1; tick(); clear = 0;
    en = 1; a = -128; b = -128; tick(); tick();
    en = 0; tick();
    chk("t6_wrap_acc", int'(ifw.acc), -32768);
    chk("t6_wrap_ovf", int'(ifw.ovf), 1);
    chk("t6_sat_acc",  int'(ifs.acc), 32767);
    chk("t6_sat_ovf",  int'(ifs.ovf), 1);
    chk("t6_main_acc", int'(ifm.acc), 32768);
    chk("t6_main_ovf", int'(ifm.ovf), 0);
    tick();
    chk("t6_wrap_sticky", int'(ifw.ovf), 1);

    // negative overflow: 3 x -16256 = -48768
    clear = 1; tick(); clear = 0;
    chk("t6_clr_ovf_w", int'(ifw.ovf), 0);
    chk("t6_clr_ovf_s", int'(ifs.ovf), 0);
    en = 1; a = -128; b = 127; tick(); tick(); tick();
    en = 0; tick();
    chk("t6_nwrap_acc", int'(ifw.acc), 16768);
    chk("t6_nwrap_ovf", int'(ifw.ovf), 1);
    chk("t6_nsat_acc",  int'(ifs.acc), -32768);
    chk("t6_nsat_ovf",  int'(ifs.ovf), 1);
    chk("t6_nmain_acc", int'(ifm.acc), -48768);
    clear = 1; tick(); clear = 0;
    chk("t6_clr2_ovf_s", int'(ifs.ovf), 0);
    chk("t6_clr2_acc_s", int'(ifs.acc), 0);

    // async reset mid-stream
    en = 1; a = 10; b = 10; tick(); tick();
    chk("t7_pre", int'(ifm.acc), 100);
    #2 rst = 1; #1;
    chk("t7_async_acc", int'(ifm.acc), 0);
    en = 0;
    @(negedge clk); rst = 0;
    tick(); chk("t7_flush", int'(ifm.acc), 0);
    tick(); chk("t7_flush2", int'(ifm.acc), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
